// File: rtl/sys_ctrl_pkg.sv
// Shared system-control definitions: command opcodes, operand addresses and
// the RX command state encoding used by both RX and TX control blocks.
package sys_ctrl_pkg;

    localparam logic [7:0] OPC_RF_WR   = 8'hAA;
    localparam logic [7:0] OPC_RF_RD   = 8'hBB;
    localparam logic [7:0] OPC_ALU_OP  = 8'hCC;
    localparam logic [7:0] OPC_ALU_NOP = 8'hDD;

    localparam int unsigned OPA_ADDR = 0;
    localparam int unsigned OPB_ADDR = 1;

    typedef enum logic [3:0] {
        IDLE,
        WR_ADDR,
        WR_DATA,
        RD_ADDR,
        RD_WAIT,
        OP_A,
        OP_B,
        ALU_FUN,
        ALU_WAIT
    } ctrl_state_e;

    // States during which the ALU clock must run
    function automatic logic is_alu_state(input ctrl_state_e s);
        return (s == OP_A) || (s == OP_B) || (s == ALU_FUN) || (s == ALU_WAIT);
    endfunction

endpackage

// File: rtl/rx_cmd_ctrl_if.sv
// RX command controller bus: UART byte stream and ALU/RF handshakes in,
// register-file and ALU control strobes out.
interface rx_cmd_ctrl_if #(
    parameter int unsigned BusWidth  = 8,
    parameter int unsigned AddrWidth = 4
) ();

    logic [BusWidth-1:0]  RX_P_Data;
    logic                 RX_D_VLD;
    logic                 ALU_OUT_VLD;
    logic                 RdData_Valid;
    logic                 RF_WrEn;
    logic                 RF_RdEn;
    logic [AddrWidth-1:0] RF_Address;
    logic [BusWidth-1:0]  RF_WrData;
    logic                 ALU_EN;
    logic [3:0]           ALU_FUN;
    logic                 CLK_GATE_EN;

    modport master (
        input  RX_P_Data, RX_D_VLD, ALU_OUT_VLD, RdData_Valid,
        output RF_WrEn, RF_RdEn, RF_Address, RF_WrData, ALU_EN, ALU_FUN, CLK_GATE_EN
    );

    modport slave (
        output RX_P_Data, RX_D_VLD, ALU_OUT_VLD, RdData_Valid,
        input  RF_WrEn, RF_RdEn, RF_Address, RF_WrData, ALU_EN, ALU_FUN, CLK_GATE_EN
    );

endinterface

// File: rtl/rx_frame_timer.sv
// Counts consecutive stalled cycles of a partial command frame and flags
// expiry on the TimeoutCycles-th stalled cycle.
module rx_frame_timer #(
    parameter int unsigned TimeoutCycles = 255
) (
    input  logic CLK,
    input  logic RST,
    input  logic stall,
    output logic expired_c
);

    localparam int unsigned CntW = $clog2(TimeoutCycles + 1);

    logic [CntW-1:0] cnt_q;

    assign expired_c = stall && (cnt_q == CntW'(TimeoutCycles - 1));

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            cnt_q <= '0;
        end else if (!stall || expired_c) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CntW'(1);
        end
    end

endmodule

// File: rtl/rx_cmd_ctrl.sv
// RX command decoder: turns UART command frames into RF write/read and ALU
// strobes. Optional frame timeout enabled by macro RX_CMD_CTRL_TIMEOUT_EN.
module rx_cmd_ctrl
    import sys_ctrl_pkg::*;
#(
    parameter int unsigned BusWidth      = 8,
    parameter int unsigned AddrWidth     = 4,
    parameter int unsigned TimeoutCycles = 255
) (
    input  logic          CLK,
    input  logic          RST,
    rx_cmd_ctrl_if.master bus
);

    localparam logic [BusWidth-1:0] OpWr    = BusWidth'(OPC_RF_WR);
    localparam logic [BusWidth-1:0] OpRd    = BusWidth'(OPC_RF_RD);
    localparam logic [BusWidth-1:0] OpAlu   = BusWidth'(OPC_ALU_OP);
    localparam logic [BusWidth-1:0] OpAluNo = BusWidth'(OPC_ALU_NOP);

    ctrl_state_e          state_q, state_nxt;
    logic [AddrWidth-1:0] wr_addr_q, wr_addr_nxt;

    logic                 wr_en_q, wr_en_nxt;
    logic                 rd_en_q, rd_en_nxt;
    logic [AddrWidth-1:0] addr_q, addr_nxt;
    logic [BusWidth-1:0]  wdata_q, wdata_nxt;
    logic                 alu_en_q, alu_en_nxt;
    logic [3:0]           alu_fun_q, alu_fun_nxt;
    logic                 gate_q, gate_nxt;

    logic                 rx_vld;
    logic [BusWidth-1:0]  rx_byte;
    logic                 timeout_c;

    assign rx_vld  = bus.RX_D_VLD;
    assign rx_byte = bus.RX_P_Data;

`ifdef RX_CMD_CTRL_TIMEOUT_EN
    logic stall_c;

    // A frame stalls when its state is waiting for an event that did not occur
    always_comb begin
        stall_c = 1'b0;
        case (state_q)
            IDLE:     stall_c = 1'b0;
            RD_WAIT:  stall_c = !bus.RdData_Valid;
            ALU_WAIT: stall_c = !bus.ALU_OUT_VLD;
            default:  stall_c = !rx_vld;
        endcase
    end

    rx_frame_timer #(
        .TimeoutCycles(TimeoutCycles)
    ) u_frame_timer (
        .CLK       (CLK),
        .RST       (RST),
        .stall     (stall_c),
        .expired_c (timeout_c)
    );
`else
    logic unused_timeout_cfg;

    assign timeout_c          = 1'b0;
    assign unused_timeout_cfg = ^32'(TimeoutCycles);
`endif

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= IDLE;
            wr_addr_q <= '0;
        end else begin
            state_q   <= state_nxt;
            wr_addr_q <= wr_addr_nxt;
        end
    end

    // Next state plus next value of every registered output
    always_comb begin
        state_nxt   = state_q;
        wr_addr_nxt = wr_addr_q;
        wr_en_nxt   = 1'b0;
        rd_en_nxt   = 1'b0;
        addr_nxt    = '0;
        wdata_nxt   = '0;
        alu_en_nxt  = 1'b0;
        alu_fun_nxt = '0;
        gate_nxt    = 1'b0;

        case (state_q)
            IDLE: begin
                if (rx_vld) begin
                    case (rx_byte)
                        OpWr:    state_nxt = WR_ADDR;
                        OpRd:    state_nxt = RD_ADDR;
                        OpAlu:   state_nxt = OP_A;
                        OpAluNo: state_nxt = ALU_FUN;
                        default: state_nxt = IDLE;
                    endcase
                end
            end
            WR_ADDR: begin
                if (rx_vld) begin
                    wr_addr_nxt = rx_byte[AddrWidth-1:0];
                    state_nxt   = WR_DATA;
                end
            end
            WR_DATA: begin
                if (rx_vld) begin
                    wr_en_nxt = 1'b1;
                    addr_nxt  = wr_addr_q;
                    wdata_nxt = rx_byte;
                    state_nxt = IDLE;
                end
            end
            RD_ADDR: begin
                if (rx_vld) begin
                    rd_en_nxt = 1'b1;
                    addr_nxt  = rx_byte[AddrWidth-1:0];
                    state_nxt = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (bus.RdData_Valid) begin
                    state_nxt = IDLE;
                end
            end
            OP_A: begin
                if (rx_vld) begin
                    wr_en_nxt = 1'b1;
                    addr_nxt  = AddrWidth'(OPA_ADDR);
                    wdata_nxt = rx_byte;
                    state_nxt = OP_B;
                end
            end
            OP_B: begin
                if (rx_vld) begin
                    wr_en_nxt = 1'b1;
                    addr_nxt  = AddrWidth'(OPB_ADDR);
                    wdata_nxt = rx_byte;
                    state_nxt = ALU_FUN;
                end
            end
            ALU_FUN: begin
                if (rx_vld) begin
                    alu_en_nxt  = 1'b1;
                    alu_fun_nxt = rx_byte[3:0];
                    state_nxt   = ALU_WAIT;
                end
            end
            ALU_WAIT: begin
                if (bus.ALU_OUT_VLD) begin
                    state_nxt = IDLE;
                end else begin
                    alu_en_nxt  = 1'b1;
                    alu_fun_nxt = alu_fun_q;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Expired frame is abandoned without issuing anything
        if (timeout_c) begin
            state_nxt   = IDLE;
            wr_en_nxt   = 1'b0;
            rd_en_nxt   = 1'b0;
            addr_nxt    = '0;
            wdata_nxt   = '0;
            alu_en_nxt  = 1'b0;
            alu_fun_nxt = '0;
        end

        gate_nxt = is_alu_state(state_nxt);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wr_en_q   <= 1'b0;
            rd_en_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            alu_en_q  <= 1'b0;
            alu_fun_q <= '0;
            gate_q    <= 1'b0;
        end else begin
            wr_en_q   <= wr_en_nxt;
            rd_en_q   <= rd_en_nxt;
            addr_q    <= addr_nxt;
            wdata_q   <= wdata_nxt;
            alu_en_q  <= alu_en_nxt;
            alu_fun_q <= alu_fun_nxt;
            gate_q    <= gate_nxt;
        end
    end

    assign bus.RF_WrEn     = wr_en_q;
    assign bus.RF_RdEn     = rd_en_q;
    assign bus.RF_Address  = addr_q;
    assign bus.RF_WrData   = wdata_q;
    assign bus.ALU_EN      = alu_en_q;
    assign bus.ALU_FUN     = alu_fun_q;
    assign bus.CLK_GATE_EN = gate_q;

endmodule

// File: tb/tb_rx_cmd_ctrl.sv
// Self-checking bench for rx_cmd_ctrl: directed frames with literal
// expectations, then random byte streams against a frame-level model.
module tb_rx_cmd_ctrl;

    localparam int unsigned TO = 16;

    logic CLK = 1'b0;
    logic RST = 1'b0;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    rx_cmd_ctrl_if #(.BusWidth(8), .AddrWidth(4)) bus ();

    rx_cmd_ctrl #(
        .BusWidth      (8),
        .AddrWidth     (4),
        .TimeoutCycles (TO)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Frame-level model: bytes of the frame in progress plus what we wait on
    logic [7:0] frame[$];
    int         wait_kind;   // 0 none, 1 RF read data, 2 ALU result
    logic [3:0] held_fun;
    int         stall_cnt;
    bit         m_prog, m_busy, m_tout;
    logic [7:0] m_b;
    logic       e_wr, e_rd, e_alu, e_gate;
    logic [3:0] e_addr, e_fun;
    logic [7:0] e_data;

    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            frame.delete();
            wait_kind = 0;
            held_fun  = '0;
            stall_cnt = 0;
            {e_wr, e_rd, e_alu, e_gate} = '0;
            e_addr = '0; e_fun = '0; e_data = '0;
        end else begin
            m_b    = bus.RX_P_Data;
            m_busy = (frame.size() != 0) || (wait_kind != 0);
            m_prog = (wait_kind == 1) ? bus.RdData_Valid :
                     (wait_kind == 2) ? bus.ALU_OUT_VLD : bus.RX_D_VLD;
            m_tout = 1'b0;
            {e_wr, e_rd, e_alu} = '0;
            e_addr = '0; e_fun = '0; e_data = '0;
`ifdef RX_CMD_CTRL_TIMEOUT_EN
            if (m_busy && !m_prog) begin
                stall_cnt++;
                if (stall_cnt == TO) begin
                    m_tout = 1'b1;
                    frame.delete();
                    wait_kind = 0;
                    stall_cnt = 0;
                end
            end else begin
                stall_cnt = 0;
            end
`endif
            if (m_tout) begin
                // frame abandoned
            end else if (wait_kind == 1) begin
                if (bus.RdData_Valid) wait_kind = 0;
            end else if (wait_kind == 2) begin
                if (bus.ALU_OUT_VLD) wait_kind = 0;
                else begin e_alu = 1'b1; e_fun = held_fun; end
            end else if (bus.RX_D_VLD) begin
                if (frame.size() != 0 || m_b inside {8'hAA, 8'hBB, 8'hCC, 8'hDD})
                    frame.push_back(m_b);
                if (frame.size() > 1) begin
                    case (frame[0])
                        8'hAA: if (frame.size() == 3) begin
                            e_wr = 1'b1; e_addr = frame[1][3:0]; e_data = frame[2];
                            frame.delete();
                        end
                        8'hBB: begin
                            e_rd = 1'b1; e_addr = frame[1][3:0];
                            frame.delete(); wait_kind = 1;
                        end
                        8'hCC: begin
                            if (frame.size() == 2) begin
                                e_wr = 1'b1; e_addr = 4'd0; e_data = frame[1];
                            end else if (frame.size() == 3) begin
                                e_wr = 1'b1; e_addr = 4'd1; e_data = frame[2];
                            end else begin
                                e_alu = 1'b1; e_fun = frame[3][3:0]; held_fun = e_fun;
                                frame.delete(); wait_kind = 2;
                            end
                        end
                        default: begin
                            e_alu = 1'b1; e_fun = frame[1][3:0]; held_fun = e_fun;
                            frame.delete(); wait_kind = 2;
                        end
                    endcase
                end
            end
            e_gate = (wait_kind == 2) ||
                     (frame.size() != 0 && (frame[0] == 8'hCC || frame[0] == 8'hDD));
        end
    end

    // Every-cycle comparison against the model
    always @(negedge CLK) begin
        if (cmp_en) begin
            chk("RF_WrEn",     32'(bus.RF_WrEn),     32'(e_wr));
            chk("RF_RdEn",     32'(bus.RF_RdEn),     32'(e_rd));
            chk("RF_Address",  32'(bus.RF_Address),  32'(e_addr));
            chk("RF_WrData",   32'(bus.RF_WrData),   32'(e_data));
            chk("ALU_EN",      32'(bus.ALU_EN),      32'(e_alu));
            chk("ALU_FUN",     32'(bus.ALU_FUN),     32'(e_fun));
            chk("CLK_GATE_EN", 32'(bus.CLK_GATE_EN), 32'(e_gate));
            chk("wr_rd_excl",  32'(bus.RF_WrEn & bus.RF_RdEn), 32'(0));
        end
    end

    task automatic send(input logic [7:0] b);
        bus.RX_P_Data = b;
        bus.RX_D_VLD  = 1'b1;
        @(negedge CLK);
        bus.RX_D_VLD  = 1'b0;
        bus.RX_P_Data = 8'($urandom);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic pulse_reset();
        @(posedge CLK); #2 RST = 1'b0;
        @(posedge CLK); #2 RST = 1'b1;
        @(negedge CLK);
    endtask

    task automatic finish_alu(input logic [3:0] fun);
        bus.ALU_OUT_VLD = 1'b1;
        chk("alu_hold_en",   32'(bus.ALU_EN),      32'(1));
        chk("alu_hold_fun",  32'(bus.ALU_FUN),     32'(fun));
        chk("alu_hold_gate", 32'(bus.CLK_GATE_EN), 32'(1));
        @(negedge CLK);
        bus.ALU_OUT_VLD = 1'b0;
        chk("alu_done_en",   32'(bus.ALU_EN),      32'(0));
        chk("alu_done_fun",  32'(bus.ALU_FUN),     32'(0));
        chk("alu_done_gate", 32'(bus.CLK_GATE_EN), 32'(0));
    endtask

    logic [7:0] opc_tab [4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};

    initial begin
        bus.RX_P_Data    = '0;
        bus.RX_D_VLD     = 1'b0;
        bus.ALU_OUT_VLD  = 1'b0;
        bus.RdData_Valid = 1'b0;
        repeat (3) @(posedge CLK);
        #2 RST = 1'b1;
        @(negedge CLK);
        cmp_en = 1'b1;

        chk("reset_wr",   32'(bus.RF_WrEn),     32'(0));
        chk("reset_rd",   32'(bus.RF_RdEn),     32'(0));
        chk("reset_alu",  32'(bus.ALU_EN),      32'(0));
        chk("reset_gate", 32'(bus.CLK_GATE_EN), 32'(0));

        // RF write frame
        send(8'hAA); send(8'h05); send(8'h3C);
        chk("wr_en",   32'(bus.RF_WrEn),    32'(1));
        chk("wr_addr", 32'(bus.RF_Address), 32'(5));
        chk("wr_data", 32'(bus.RF_WrData),  32'(8'h3C));
        idle(1);
        chk("wr_pulse_end", 32'(bus.RF_WrEn),    32'(0));
        chk("wr_addr_zero", 32'(bus.RF_Address), 32'(0));

        // RF read frame; bytes during the wait are dropped
        send(8'hBB); send(8'h07);
        chk("rd_en",   32'(bus.RF_RdEn),    32'(1));
        chk("rd_addr", 32'(bus.RF_Address), 32'(7));
        send(8'hDD); send(8'h01);
        idle(3);
        chk("rd_pulse_end", 32'(bus.RF_RdEn), 32'(0));
        chk("rd_wait_drop", 32'(bus.ALU_EN),  32'(0));
        bus.RdData_Valid = 1'b1;
        @(negedge CLK);
        bus.RdData_Valid = 1'b0;

        // ALU with operands
        send(8'hCC);
        chk("cc_gate", 32'(bus.CLK_GATE_EN), 32'(1));
        send(8'h12);
        chk("opa_wr",   32'(bus.RF_WrEn),    32'(1));
        chk("opa_addr", 32'(bus.RF_Address), 32'(0));
        chk("opa_data", 32'(bus.RF_WrData),  32'(8'h12));
        send(8'h34);
        chk("opb_addr", 32'(bus.RF_Address), 32'(1));
        chk("opb_data", 32'(bus.RF_WrData),  32'(8'h34));
        send(8'h02);
        chk("cc_alu_en",  32'(bus.ALU_EN),  32'(1));
        chk("cc_alu_fun", 32'(bus.ALU_FUN), 32'(2));
        idle(4);
        finish_alu(4'd2);

        // Unknown opcode then ALU without operands
        send(8'h55);
        chk("unk_gate", 32'(bus.CLK_GATE_EN), 32'(0));
        send(8'hDD); send(8'h01);
        chk("dd_alu_en",  32'(bus.ALU_EN),  32'(1));
        chk("dd_alu_fun", 32'(bus.ALU_FUN), 32'(1));
        finish_alu(4'd1);

        // Reset abandons a partial write frame
        send(8'hAA); send(8'h03);
        pulse_reset();
        send(8'h77);
        chk("rst_no_wr_a", 32'(bus.RF_WrEn), 32'(0));
        send(8'h3C);
        chk("rst_no_wr_b", 32'(bus.RF_WrEn), 32'(0));

`ifdef RX_CMD_CTRL_TIMEOUT_EN
        send(8'hAA);
        idle(TO);
        send(8'h09);
        chk("to_no_wr_a", 32'(bus.RF_WrEn), 32'(0));
        send(8'h3C);
        chk("to_no_wr_b", 32'(bus.RF_WrEn), 32'(0));
`endif

        // Random byte streams with random handshakes and rare resets
        for (int i = 0; i < 4000; i++) begin
            bus.RX_D_VLD     = ($urandom_range(0, 2) == 0);
            bus.RX_P_Data    = ($urandom_range(0, 9) < 5) ? opc_tab[$urandom_range(0, 3)]
                                                           : 8'($urandom);
            bus.RdData_Valid = ($urandom_range(0, 4) == 0);
            bus.ALU_OUT_VLD  = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 499) == 0) pulse_reset();
            else @(negedge CLK);
        end
        bus.RX_D_VLD = 1'b0;
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
